// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock sampled in the clk domain and
// flags sticky period/duty/stuck errors. Define CLK_MON_STATS_EN for min/max period tracking.
module clk_div_monitor #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TOL         = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [CNT_W-1:0] exp_high,
  input  logic             clk_div_in,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic             meas_valid,
  output logic             err_period,
  output logic             err_duty,
  output logic             err_stuck,
  output logic             stuck_level
`ifdef CLK_MON_STATS_EN
  ,
  output logic [CNT_W-1:0] min_period,
  output logic [CNT_W-1:0] max_period
`endif
);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_ALL    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]   TOL_V      = (CNT_W + 1)'(TOL);

  state_t             state_q;
  state_t             state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               s;
  logic               s_d;
  logic               rise;
  logic               fall;
  logic               active;
  logic               timeout;
  logic [CNT_W-1:0]   per_cnt;
  logic [CNT_W-1:0]   hi_len;
  logic [CNT_W-1:0]   idle_cnt;
  logic               start_period;
  logic               capture;
  logic               hi_capture;
  logic               count;
  logic               clear_cnt;
  logic               per_bad;
  logic               hi_bad;

  function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
    logic [CNT_W:0] ax;
    logic [CNT_W:0] bx;
    ax = {1'b0, a};
    bx = {1'b0, b};
    return (ax >= bx) ? (ax - bx) : (bx - ax);
  endfunction

  // clk_div_in is asynchronous to us; only the last stage and its delayed copy are used
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_div_in};
      s_d    <= s;
    end
  end

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~s_d;
  assign fall    = ~s & s_d;
  assign active  = en && (state_q != IDLE);
  assign timeout = active && !rise && !fall && (idle_cnt == TIMEOUT_M1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else if (timeout) begin
      state_d = ARM;
    end else begin
      case (state_q)
        IDLE:    state_d = ARM;
        ARM:     if (rise) state_d = HIGH;
        HIGH:    if (fall) state_d = LOW;
        LOW:     if (rise) state_d = HIGH;
        default: state_d = IDLE;
      endcase
    end
  end

  // A rise in ARM only starts counting; a rise in LOW also closes the period
  always_comb begin
    start_period = 1'b0;
    capture      = 1'b0;
    hi_capture   = 1'b0;
    count        = 1'b0;
    clear_cnt    = 1'b0;
    if (!en || timeout) begin
      clear_cnt = 1'b1;
    end else begin
      case (state_q)
        IDLE: clear_cnt = 1'b1;
        ARM:  start_period = rise;
        HIGH: begin
          count      = 1'b1;
          hi_capture = fall;
        end
        LOW: begin
          count        = 1'b1;
          start_period = rise;
          capture      = rise;
        end
        default: clear_cnt = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt  <= '0;
      hi_len   <= '0;
      idle_cnt <= '0;
    end else begin
      if (clear_cnt)                          per_cnt <= '0;
      else if (start_period)                  per_cnt <= CNT_ONE;
      else if (count && (per_cnt != CNT_ALL)) per_cnt <= per_cnt + CNT_ONE;

      if (clear_cnt)       hi_len <= '0;
      else if (hi_capture) hi_len <= per_cnt;

      if (!active || rise || fall || timeout) idle_cnt <= '0;
      else                                    idle_cnt <= idle_cnt + CNT_ONE;
    end
  end

  assign per_bad = abs_diff(per_cnt, exp_period) > TOL_V;
  assign hi_bad  = abs_diff(hi_len, exp_high) > TOL_V;

  // Error flags are judged on the values being captured, so a set beats a same-cycle clr
  always_ff @(posedge clk) begin
    if (rst) begin
      meas_period <= '0;
      meas_high   <= '0;
      meas_valid  <= 1'b0;
      err_period  <= 1'b0;
      err_duty    <= 1'b0;
      err_stuck   <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      meas_valid <= capture;
      if (capture) begin
        meas_period <= per_cnt;
        meas_high   <= hi_len;
      end

      if (capture && per_bad) err_period <= 1'b1;
      else if (clr)           err_period <= 1'b0;

      if (capture && hi_bad)  err_duty <= 1'b1;
      else if (clr)           err_duty <= 1'b0;

      if (timeout)            err_stuck <= 1'b1;
      else if (clr)           err_stuck <= 1'b0;

      if (timeout)            stuck_level <= s;
    end
  end

`ifdef CLK_MON_STATS_EN
  logic [CNT_W-1:0] min_base;
  logic [CNT_W-1:0] max_base;

  assign min_base = clr ? CNT_ALL : min_period;
  assign max_base = clr ? '0 : max_period;

  always_ff @(posedge clk) begin
    if (rst) begin
      min_period <= CNT_ALL;
      max_period <= '0;
    end else if (capture) begin
      min_period <= (per_cnt < min_base) ? per_cnt : min_base;
      max_period <= (per_cnt > max_base) ? per_cnt : max_base;
    end else begin
      min_period <= min_base;
      max_period <= max_base;
    end
  end
`endif

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed self-checking bench for clk_div_monitor; exercises the CLK_MON_STATS_EN
// outputs when that macro is defined.
module tb_clk_div_monitor;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic [7:0] exp_period;
  logic [7:0] exp_high;
  logic       clk_div_in;
  logic [7:0] meas_period;
  logic [7:0] meas_high;
  logic       meas_valid;
  logic       err_period;
  logic       err_duty;
  logic       err_stuck;
  logic       stuck_level;
`ifdef CLK_MON_STATS_EN
  logic [7:0] min_period;
  logic [7:0] max_period;
`endif

  int compared;
  int mismatched;
  int phase;
  int valid_cnt;
  int first_valid_iter;
  int last_valid_iter;
  int gap_min;
  int gap_max;
  int first_stuck_iter;

  clk_div_monitor #(
    .CNT_W(8),
    .SYNC_STAGES(2),
    .TOL(1),
    .TIMEOUT(255)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .clr(clr),
    .exp_period(exp_period),
    .exp_high(exp_high),
    .clk_div_in(clk_div_in),
    .meas_period(meas_period),
    .meas_high(meas_high),
    .meas_valid(meas_valid),
    .err_period(err_period),
    .err_duty(err_duty),
    .err_stuck(err_stuck),
    .stuck_level(stuck_level)
`ifdef CLK_MON_STATS_EN
    ,
    .min_period(min_period),
    .max_period(max_period)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives a hi/lo waveform for a fixed number of cycles and records what meas_valid and err_stuck did
  task automatic applyStimulus(input int hi, input int lo, input int cycles);
    int gap;
    valid_cnt        = 0;
    first_valid_iter = -1;
    last_valid_iter  = -1;
    gap_min          = 1000000;
    gap_max          = 0;
    first_stuck_iter = -1;
    for (int i = 0; i < cycles; i++) begin
      clk_div_in = (phase < hi);
      phase      = (phase + 1) % (hi + lo);
      @(posedge clk);
      #1;
      if (meas_valid === 1'b1) begin
        if (last_valid_iter >= 0) begin
          gap = i - last_valid_iter;
          if (gap < gap_min) gap_min = gap;
          if (gap > gap_max) gap_max = gap;
        end else begin
          first_valid_iter = i;
        end
        last_valid_iter = i;
        valid_cnt++;
      end
      if ((err_stuck === 1'b1) && (first_stuck_iter < 0)) first_stuck_iter = i;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic restartMonitor();
    en    = 1'b0;
    clr   = 1'b1;
    phase = 0;
    applyStimulus(0, 1, 4);
    clr   = 1'b0;
    phase = 0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    phase      = 0;
    rst        = 1'b1;
    en         = 1'b0;
    clr        = 1'b0;
    exp_period = 8'd9;
    exp_high   = 8'd4;
    clk_div_in = 1'b0;

    applyStimulus(0, 1, 3);
    checkOutput("rst_meas_period", 32'(meas_period), 0);
    checkOutput("rst_meas_high", 32'(meas_high), 0);
    checkOutput("rst_meas_valid", 32'(meas_valid), 0);
    checkOutput("rst_err_period", 32'(err_period), 0);
    checkOutput("rst_err_duty", 32'(err_duty), 0);
    checkOutput("rst_err_stuck", 32'(err_stuck), 0);
    checkOutput("rst_stuck_level", 32'(stuck_level), 0);
`ifdef CLK_MON_STATS_EN
    checkOutput("rst_min_period", 32'(min_period), 255);
    checkOutput("rst_max_period", 32'(max_period), 0);
`endif
    rst = 1'b0;

    $display("[TB] high 4 / low 5, expecting 9/4");
    en    = 1'b1;
    phase = 0;
    applyStimulus(4, 5, 100);
    checkOutput("nom_valid_count", valid_cnt, 10);
    checkOutput("nom_first_valid", first_valid_iter, 11);
    checkOutput("nom_gap_min", gap_min, 9);
    checkOutput("nom_gap_max", gap_max, 9);
    checkOutput("nom_meas_period", 32'(meas_period), 9);
    checkOutput("nom_meas_high", 32'(meas_high), 4);
    checkOutput("nom_err_period", 32'(err_period), 0);
    checkOutput("nom_err_duty", 32'(err_duty), 0);
    checkOutput("nom_err_stuck", 32'(err_stuck), 0);

    $display("[TB] expecting period 7 against a 9-cycle clock");
    exp_period = 8'd7;
    applyStimulus(4, 5, 20);
    checkOutput("per_valid_count", valid_cnt, 3);
    checkOutput("per_err_period", 32'(err_period), 1);
    checkOutput("per_err_duty", 32'(err_duty), 0);
    clr = 1'b1;
    applyStimulus(4, 5, 1);
    clr = 1'b0;
    checkOutput("per_err_after_clr", 32'(err_period), 0);
    applyStimulus(4, 5, 9);
    checkOutput("per_revalid_count", valid_cnt, 1);
    checkOutput("per_err_reset", 32'(err_period), 1);

    $display("[TB] high 2 / low 7, expecting high 4");
    exp_period = 8'd9;
    exp_high   = 8'd4;
    restartMonitor();
    checkOutput("duty_idle_no_valid", valid_cnt, 0);
    checkOutput("duty_clr_err_period", 32'(err_period), 0);
    en = 1'b1;
    applyStimulus(2, 7, 40);
    checkOutput("duty_valid_count", valid_cnt, 4);
    checkOutput("duty_meas_high", 32'(meas_high), 2);
    checkOutput("duty_meas_period", 32'(meas_period), 9);
    checkOutput("duty_err_duty", 32'(err_duty), 1);
    checkOutput("duty_err_period", 32'(err_period), 0);

    $display("[TB] stuck-high timeout");
    restartMonitor();
    en = 1'b1;
    applyStimulus(4, 5, 20);
    checkOutput("stuck_pre_valid_count", valid_cnt, 1);
    phase = 0;
    applyStimulus(1, 0, 300);
    checkOutput("stuck_first_iter", first_stuck_iter, 255);
    checkOutput("stuck_err", 32'(err_stuck), 1);
    checkOutput("stuck_level", 32'(stuck_level), 1);
    phase = 0;
    applyStimulus(4, 5, 40);
    checkOutput("resume_valid_count", valid_cnt, 3);
    checkOutput("resume_first_valid", first_valid_iter, 20);
    checkOutput("resume_meas_period", 32'(meas_period), 9);
    checkOutput("resume_meas_high", 32'(meas_high), 4);
    checkOutput("resume_err_sticky", 32'(err_stuck), 1);

    $display("[TB] enable dropped mid-HIGH");
    restartMonitor();
    checkOutput("abort_stuck_cleared", 32'(err_stuck), 0);
    en = 1'b1;
    applyStimulus(4, 5, 4);
    en = 1'b0;
    applyStimulus(4, 5, 3);
    checkOutput("abort_disabled_valid", valid_cnt, 0);
    en = 1'b1;
    applyStimulus(4, 5, 30);
    checkOutput("abort_valid_count", valid_cnt, 2);
    checkOutput("abort_first_valid", first_valid_iter, 13);
    checkOutput("abort_meas_period", 32'(meas_period), 9);

    $display("[TB] saturating 400-cycle period");
    restartMonitor();
    en = 1'b1;
    applyStimulus(200, 200, 810);
    checkOutput("sat_valid_count", valid_cnt, 2);
    checkOutput("sat_meas_period", 32'(meas_period), 255);
    checkOutput("sat_meas_high", 32'(meas_high), 200);
    checkOutput("sat_err_period", 32'(err_period), 1);
    checkOutput("sat_err_duty", 32'(err_duty), 1);
    checkOutput("sat_err_stuck", 32'(err_stuck), 0);

`ifdef CLK_MON_STATS_EN
    $display("[TB] alternating 9/10 periods for min/max");
    restartMonitor();
    checkOutput("stats_clr_min", 32'(min_period), 255);
    checkOutput("stats_clr_max", 32'(max_period), 0);
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      phase = 0;
      applyStimulus(4, 5, 9);
      phase = 0;
      applyStimulus(4, 6, 10);
    end
    checkOutput("stats_min", 32'(min_period), 9);
    checkOutput("stats_max", 32'(max_period), 10);
    restartMonitor();
    checkOutput("stats_min_after_clr", 32'(min_period), 255);
    checkOutput("stats_max_after_clr", 32'(max_period), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
